banked_mem_array: RTL and testbench
===================================

Name: banked_mem_array

Overview:
- Parametrised N-bank memory for the NTT datapath; each bank is a simple dual-port RAM with one write port and one read port, all sharing one clock.
- Adds features the earlier fixed 8-bit-address, 32-bit-data bank array lacks:
  - configurable width, depth (need not be a power of two), bank count and read latency;
  - per-bank read enable with valid flags;
  - post-reset zero-clear sequencer;
  - out-of-range detection.
- Feeds butterfly units and receives their results.

Parameters:
- N, 5, number of banks.
- WIDTH, 32, data bits per bank word.
- DEPTH, 256, words per bank; any value from 2 to 2^AW.
- AW, 8, address bits per bank.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ready  out  1  high once the clear sweep is done; user accesses are accepted only while high.
- we  in  N  per-bank write enable.
- re  in  N  per-bank read enable.
- addr_write  in  N*AW  bank i uses bits [i*AW +: AW].
- addr_read  in  N*AW  bank i uses bits [i*AW +: AW].
- din  in  N*WIDTH  bank i uses bits [i*WIDTH +: WIDTH].
- dout  out  N*WIDTH  read data; bank i uses bits [i*WIDTH +: WIDTH].
- dout_valid  out  N  per-bank read-data valid.
- oor_err  out  N  sticky per-bank flag: an out-of-range address was presented.

Behaviour:
- Reset values (rst asserted, asynchronously):
  - ready=0, dout=0, dout_valid=0, oor_err=0;
  - clear counter = 0; FSM enters CLEAR;
  - all read-pipeline registers cleared.
- FSM has two states, CLEAR and RUN.
  - CLEAR: each cycle writes 0 to address clr_cnt in every bank, then increments clr_cnt.
  - When the cycle with clr_cnt = DEPTH-1 is written, the FSM moves to RUN. ready rises on the following edge, exactly DEPTH cycles after rst deasserts.
  - RUN: ready=1; the FSM stays in RUN until rst.
- While ready=0: we, re and addresses are ignored; dout_valid stays 0; oor_err is not updated.
- Write (RUN): at a rising edge with we[i]=1 and addr_write_i < DEPTH, bank i stores din_i at addr_write_i.
- Read (RUN), re[i]=1 and addr_read_i < DEPTH:
  - READ_LAT=1: dout_i and dout_valid[i]=1 appear after the next edge.
  - READ_LAT=2: an extra output register adds one cycle.
  - A new read may be issued every cycle; reads are fully pipelined.
- re[i]=0: dout_valid[i] goes 0 at the same pipeline position; dout_i holds its last value.
- Out of range, address >= DEPTH:
  - a write is dropped, and oor_err[i] is set on that edge;
  - a read returns dout_i=0 with dout_valid[i]=1, and oor_err[i] is set;
  - oor_err is cleared only by rst.
- Same-cycle write and read of the same address in one bank: the result is set by the optional feature below.
- Banks are independent; there are no cross-bank conflicts.
- Reset mid-operation: the in-flight read pipeline is flushed (dout_valid=0 immediately); CLEAR restarts from address 0.
- Memory contents do not need an async reset; the CLEAR sweep is the only guaranteed initialisation.

Optional Feature:
- Macro: BANKED_MEM_ARRAY_BYPASS_EN.
- Defined: a read that hits the same bank and address as a same-cycle write returns the new din value (write-first forwarding), at normal READ_LAT.
- Undefined: the read returns the previously stored word (read-first). The write still completes.

Test Plan:
- Reset, DEPTH=256 → ready=0 for exactly 256 cycles after rst falls, then 1. A read of any address returns 0 with dout_valid=1.
- Writes, READ_LAT=1:
  - write bank0 @0=32'h12345678, bank1 @1=32'h0000DEAF, bank4 @4=32'h00ABCDEF in one cycle;
  - next cycle read the same addresses;
  - → one cycle later dout carries those words and dout_valid=5'b10011.
- Same-cycle write/read: write bank2 @7=32'hCAFEF00D and read bank2 @7 on the same edge → with the macro, dout_2=32'hCAFEF00D; without it, dout_2=0.
- Latency and throughput, READ_LAT=2, DEPTH=200:
  - read addresses 0..9 back-to-back → dout_valid high for 10 consecutive cycles, starting 2 cycles after the first re;
  - read address 200 → dout_i=0 and oor_err[i]=1, which persists.
- rst asserted mid-stream with reads in flight → dout_valid drops to 0 at once; ready=0; a full CLEAR follows (DEPTH cycles); earlier data reads back as 0.
- we=5'b11111 asserted during CLEAR → ignored; all words still read 0 after ready rises.

Source files
------------

// File: rtl/banked_mem_array_if.sv
// Bus bundle for banked_mem_array: per-bank write/read ports,
// read data with valid flags, ready and sticky out-of-range flags.
interface banked_mem_array_if #(
  parameter int N     = 5,
  parameter int WIDTH = 32,
  parameter int AW    = 8
);
  logic               ready;
  logic [N-1:0]       we;
  logic [N-1:0]       re;
  logic [N*AW-1:0]    addr_write;
  logic [N*AW-1:0]    addr_read;
  logic [N*WIDTH-1:0] din;
  logic [N*WIDTH-1:0] dout;
  logic [N-1:0]       dout_valid;
  logic [N-1:0]       oor_err;

  modport master (
    input  ready, dout, dout_valid, oor_err,
    output we, re, addr_write, addr_read, din
  );

  modport slave (
    output ready, dout, dout_valid, oor_err,
    input  we, re, addr_write, addr_read, din
  );
endinterface

// File: rtl/banked_mem_array.sv
// N-bank simple dual-port RAM array with post-reset zero sweep.
// Define BANKED_MEM_ARRAY_BYPASS_EN for write-first forwarding.
module banked_mem_array #(
  parameter int N        = 5,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  banked_mem_array_if.slave   bus
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW:0]   DLIM = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_nxt;
  logic          run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_cnt;
    unique case (1'b1)
      (state == CLEAR): begin
        clr_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST) begin
          state_nxt = RUN;
          clr_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  assign run       = (state == RUN);
  assign bus.ready = run;

  for (genvar g = 0; g < N; g++) begin : g_bank
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    waddr, raddr, wa_m;
    logic [WIDTH-1:0] wdat, wd_m, rd_word;
    logic             w_ok, r_ok, wr_en, rd_req;
    logic [WIDTH-1:0] d1, dq;
    logic             v1, vq, oor;

    assign waddr = bus.addr_write[g*AW +: AW];
    assign raddr = bus.addr_read[g*AW +: AW];
    assign wdat  = bus.din[g*WIDTH +: WIDTH];
    assign w_ok  = {1'b0, waddr} < DLIM;
    assign r_ok  = {1'b0, raddr} < DLIM;

    // The clear sweep owns the write port until RUN
    assign wr_en  = run ? (bus.we[g] & w_ok) : 1'b1;
    assign wa_m   = run ? waddr : clr_cnt;
    assign wd_m   = run ? wdat : '0;
    assign rd_req = run & bus.re[g];

    always_ff @(posedge clk) begin
      if (wr_en) mem[wa_m] <= wd_m;
    end

`ifdef BANKED_MEM_ARRAY_BYPASS_EN
    logic fwd;
    assign fwd     = bus.we[g] & w_ok & (waddr == raddr);
    assign rd_word = fwd ? wdat : mem[raddr];
`else
    assign rd_word = mem[raddr];
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v1 <= 1'b0;
        d1 <= '0;
      end else begin
        v1 <= rd_req;
        if (rd_req) d1 <= r_ok ? rd_word : '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        oor <= 1'b0;
      end else if (run) begin
        if ((bus.we[g] & ~w_ok) | (bus.re[g] & ~r_ok))
          oor <= 1'b1;
      end
    end

    if (READ_LAT == 2) begin : g_l2
      logic [WIDTH-1:0] d2;
      logic             v2;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end
      assign dq = d2;
      assign vq = v2;
    end else begin : g_l1
      assign dq = d1;
      assign vq = v1;
    end

    assign bus.dout[g*WIDTH +: WIDTH] = dq;
    assign bus.dout_valid[g]          = vq;
    assign bus.oor_err[g]             = oor;
  end

endmodule

// File: tb/tb_banked_mem_array.sv
// Bench for banked_mem_array: two instances (depth 256 / latency 1 and
// depth 200 / latency 2) driven identically and checked against a model.
module tb_banked_mem_array;
  localparam int N  = 5;
  localparam int W  = 32;
  localparam int AW = 8;
  localparam int DA = 256;
  localparam int DB = 200;

  typedef logic [N*W-1:0] wide_t;

  typedef struct packed {
    logic [N-1:0]    we;
    logic [N-1:0]    re;
    logic [N*AW-1:0] wa;
    logic [N*AW-1:0] ra;
    logic [N*W-1:0]  din;
    logic [N-1:0]    xv;
    logic [N-1:0]    xmask;
    logic [N*W-1:0]  xd;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    we, re;
  logic [N*AW-1:0] wa, ra;
  logic [N*W-1:0]  din;

  always #5 clk = ~clk;

  banked_mem_array_if #(.N(N), .WIDTH(W), .AW(AW)) bus_a ();
  banked_mem_array_if #(.N(N), .WIDTH(W), .AW(AW)) bus_b ();

  assign bus_a.we = we;
  assign bus_a.re = re;
  assign bus_a.addr_write = wa;
  assign bus_a.addr_read = ra;
  assign bus_a.din = din;
  assign bus_b.we = we;
  assign bus_b.re = re;
  assign bus_b.addr_write = wa;
  assign bus_b.addr_read = ra;
  assign bus_b.din = din;

  banked_mem_array #(
    .N(N), .WIDTH(W), .DEPTH(DA), .AW(AW), .READ_LAT(1)
  ) u_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave)
  );

  banked_mem_array #(
    .N(N), .WIDTH(W), .DEPTH(DB), .AW(AW), .READ_LAT(2)
  ) u_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  // Reference model: memory image, sticky flags, expected outputs
  logic [W-1:0] mem [2][N][256];
  int           cnt [2];
  logic [N-1:0] oor_m [2];
  logic [N-1:0] ev [2];
  logic [N-1:0] pv [2];
  logic [W-1:0] ed [2][N];
  logic [W-1:0] pd [2][N];
  int compared = 0;
  int mismatched = 0;

  function automatic int dep(int d);
    return (d == 0) ? DA : DB;
  endfunction

  function automatic wide_t pack(int d);
    wide_t r;
    for (int i = 0; i < N; i++) r[i*W +: W] = ed[d][i];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        for (int a = 0; a < 256; a++) mem[d][i][a] = '0;
        ed[d][i] = '0;
        pd[d][i] = '0;
      end
      cnt[d] = 0;
      oor_m[d] = '0;
      ev[d] = '0;
      pv[d] = '0;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] rv;
    logic [W-1:0] rd [N];
    int wai, rai;
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      rv = '0;
      for (int i = 0; i < N; i++) rd[i] = '0;
      if (cnt[d] >= dep(d)) begin
        for (int i = 0; i < N; i++) begin
          wai = int'(wa[i*AW +: AW]);
          rai = int'(ra[i*AW +: AW]);
          if (re[i]) begin
            rv[i] = 1'b1;
            if (rai >= dep(d)) begin
              oor_m[d][i] = 1'b1;
            end else begin
              rd[i] = mem[d][i][rai];
`ifdef BANKED_MEM_ARRAY_BYPASS_EN
              if (we[i] && wai == rai) rd[i] = din[i*W +: W];
`endif
            end
          end
          if (we[i]) begin
            if (wai < dep(d)) mem[d][i][wai] = din[i*W +: W];
            else oor_m[d][i] = 1'b1;
          end
        end
      end
      if (d == 0) begin
        ev[d] = rv;
        for (int i = 0; i < N; i++) if (rv[i]) ed[d][i] = rd[i];
      end else begin
        ev[d] = pv[d];
        for (int i = 0; i < N; i++) if (pv[d][i]) ed[d][i] = pd[d][i];
        pv[d] = rv;
        for (int i = 0; i < N; i++) pd[d][i] = rd[i];
      end
      cnt[d]++;
    end
  endtask

  task automatic chk(string nm, wide_t act, wide_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("A ready", wide_t'(bus_a.ready), wide_t'(cnt[0] >= DA));
    chk("A valid", wide_t'(bus_a.dout_valid), wide_t'(ev[0]));
    chk("A oor", wide_t'(bus_a.oor_err), wide_t'(oor_m[0]));
    chk("A dout", bus_a.dout, pack(0));
    chk("B ready", wide_t'(bus_b.ready), wide_t'(cnt[1] >= DB));
    chk("B valid", wide_t'(bus_b.dout_valid), wide_t'(ev[1]));
    chk("B oor", wide_t'(bus_b.oor_err), wide_t'(oor_m[1]));
    chk("B dout", bus_b.dout, pack(1));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    we = '0;
    re = '0;
  endtask

  task automatic rand_in(int amax);
    we = N'($urandom);
    re = N'($urandom);
    for (int i = 0; i < N; i++) begin
      wa[i*AW +: AW] = AW'($urandom_range(0, amax));
      ra[i*AW +: AW] = AW'($urandom_range(0, amax));
      din[i*W +: W] = $urandom;
    end
  endtask

  vec_t tbl [5];

  initial begin
    int bl, bf;
    tbl[0] = '0;
    tbl[0].we = 5'b10011;
    tbl[0].wa[1*AW +: AW] = 8'd1;
    tbl[0].wa[4*AW +: AW] = 8'd4;
    tbl[0].din[0*W +: W] = 32'h12345678;
    tbl[0].din[1*W +: W] = 32'h0000DEAF;
    tbl[0].din[4*W +: W] = 32'h00ABCDEF;
    tbl[1] = '0;
    tbl[1].re = 5'b10011;
    tbl[1].ra[1*AW +: AW] = 8'd1;
    tbl[1].ra[4*AW +: AW] = 8'd4;
    tbl[1].xv = 5'b10011;
    tbl[1].xmask = 5'b10011;
    tbl[1].xd[0*W +: W] = 32'h12345678;
    tbl[1].xd[1*W +: W] = 32'h0000DEAF;
    tbl[1].xd[4*W +: W] = 32'h00ABCDEF;
    tbl[2] = '0;
    tbl[2].we = 5'b00100;
    tbl[2].re = 5'b00100;
    tbl[2].wa[2*AW +: AW] = 8'd7;
    tbl[2].ra[2*AW +: AW] = 8'd7;
    tbl[2].din[2*W +: W] = 32'hCAFEF00D;
    tbl[2].xv = 5'b00100;
    tbl[2].xmask = 5'b00100;
`ifdef BANKED_MEM_ARRAY_BYPASS_EN
    tbl[2].xd[2*W +: W] = 32'hCAFEF00D;
`endif
    tbl[3] = '0;
    tbl[3].re = 5'b00100;
    tbl[3].ra[2*AW +: AW] = 8'd7;
    tbl[3].xv = 5'b00100;
    tbl[3].xmask = 5'b00100;
    tbl[3].xd[2*W +: W] = 32'hCAFEF00D;
    tbl[4] = '0;
    tbl[4].re = 5'b01000;
    tbl[4].ra[3*AW +: AW] = 8'd255;
    tbl[4].xv = 5'b01000;
    tbl[4].xmask = 5'b01000;

    idle();
    wa = '0;
    ra = '0;
    din = '0;
    #1;
    model_reset();
    compare_all();
    step();
    step();
    rst = 1'b0;

    // Clear sweep with every write enable held high
    for (int k = 0; k < DA; k++) begin
      rand_in(255);
      we = '1;
      step();
    end
    for (int k = 0; k < 20; k++) begin
      rand_in(255);
      we = '0;
      step();
    end

    for (int k = 0; k < 5; k++) begin
      we = tbl[k].we;
      re = tbl[k].re;
      wa = tbl[k].wa;
      ra = tbl[k].ra;
      din = tbl[k].din;
      step();
      chk("tbl valid", wide_t'(bus_a.dout_valid), wide_t'(tbl[k].xv));
      for (int i = 0; i < N; i++)
        if (tbl[k].xmask[i])
          chk("tbl dout", wide_t'(bus_a.dout[i*W +: W]),
              wide_t'(tbl[k].xd[i*W +: W]));
    end

    // Reset with reads in flight
    for (int k = 0; k < 3; k++) begin
      rand_in(15);
      re = '1;
      step();
    end
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst flush A", wide_t'(bus_a.dout_valid), wide_t'(0));
    chk("rst flush B", wide_t'(bus_b.dout_valid), wide_t'(0));
    compare_all();
    idle();
    step();
    rst = 1'b0;
    for (int k = 0; k < DA; k++) step();

    // Back-to-back reads of 0..9 on every bank
    bl = 0;
    bf = -1;
    for (int k = 0; k < 15; k++) begin
      if (k < 10) begin
        re = '1;
        for (int i = 0; i < N; i++) ra[i*AW +: AW] = AW'(k);
      end else begin
        idle();
      end
      step();
      if (bus_b.dout_valid == '1) begin
        bl++;
        if (bf < 0) bf = k;
      end
      if (k == 0)
        chk("post-rst bank0", wide_t'(bus_a.dout[0 +: W]), wide_t'(0));
    end
    chk("B burst len", wide_t'(bl), wide_t'(10));
    chk("B burst start", wide_t'(bf), wide_t'(1));

    re = 5'b00010;
    ra[1*AW +: AW] = 8'd200;
    step();
    idle();
    for (int k = 0; k < 4; k++) step();
    chk("B oor set", wide_t'(bus_b.oor_err), wide_t'(5'b00010));
    chk("A oor clear", wide_t'(bus_a.oor_err), wide_t'(0));

    for (int k = 0; k < 600; k++) begin
      rand_in(k < 300 ? 15 : 255);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
